clk_divider_multi: RTL and testbench

Parametrised, multi-channel successor to the single 32-bit clock divider. Each channel divides the system clock by a runtime-programmable divisor. Each channel produces a 50%-duty divided output and a one-cycle rising-edge tick for downstream FSMs such as the LED pattern machines. New divisors are double-buffered and take effect only at a toggle boundary, so divisor changes never produce runt pulses.

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_divider_multi_if.sv | 41 ++++
 rtl/clk_div_channel.sv | 103 ++++++++++
 rtl/clk_divider_multi.sv | 52 +++++
 tb/tb_clk_divider_multi.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared defaults and the channel-slice offset helper for the
//               multi-channel clock divider.
//               - DEF_WIDTH     : divisor/counter width per channel
//               - DEF_CHANNELS  : number of divider channels
//               - DEF_RESET_DIV : active divisor loaded on reset
//               - chan_offset() : LSB position of channel k in a packed bus
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_CHANNELS  = 4;
   localparam int unsigned DEF_RESET_DIV = 2;

   // Channel k occupies bits [k*width +: width] of a packed per-channel bus.
   function automatic int unsigned chan_offset(input int unsigned k,
                                               input int unsigned width);
      return k * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_divider_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_divider_multi_if
// Description : Control/status bundle of the multi-channel clock divider.
//               master (controller) drives enable, divisor, load and
//               observes outclk, tick, pending.
//               slave  (divider)    is the reverse.
//               - enable  [CHANNELS]       : per-channel run enable
//               - divisor [CHANNELS*WIDTH] : half-period per channel
//               - load    [CHANNELS]       : capture divisor into shadow
//               - outclk  [CHANNELS]       : divided square wave
//               - tick    [CHANNELS]       : one-cycle pulse on rising outclk
//               - pending [CHANNELS]       : shadow captured, not yet applied
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_divider_multi_if
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned CHANNELS = DEF_CHANNELS
);

   logic [CHANNELS-1:0]       enable;
   logic [CHANNELS*WIDTH-1:0] divisor;
   logic [CHANNELS-1:0]       load;
   logic [CHANNELS-1:0]       outclk;
   logic [CHANNELS-1:0]       tick;
   logic [CHANNELS-1:0]       pending;

   modport master (
      output enable, divisor, load,
      input  outclk, tick, pending
   );

   modport slave (
      input  enable, divisor, load,
      output outclk, tick, pending
   );

endinterface
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_channel
// Description : One divider channel with double-buffered divisor.
//               - clock   in  : system clock (rising edge)
//               - reset   in  : asynchronous, active-low
//               - enable  in  : run enable
//               - divisor in  : new half-period value
//               - load    in  : capture divisor into shadow register
//               - outclk  out : divided square wave, period 2*A
//               - tick    out : one-cycle pulse in first high cycle of outclk
//               - pending out : shadow captured, not yet applied
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_channel #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RESET_DIV = 2
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             enable,
   input  wire logic [WIDTH-1:0] divisor,
   input  wire logic             load,
   output logic                  outclk,
   output logic                  tick,
   output logic                  pending
);

   logic [WIDTH-1:0] cnt_q,  cnt_d;
   logic [WIDTH-1:0] act_q,  act_d;   // active divisor A
   logic [WIDTH-1:0] shd_q,  shd_d;   // shadow divisor S
   logic             pend_q, pend_d;
   logic             out_q,  out_d;
   logic             tick_q, tick_d;

   logic             w_idle;
   logic             w_boundary;
   logic             w_apply;

   // A==0 is treated exactly like a disabled channel: held low, and a pending
   // shadow is applied without waiting for a boundary that will never come.
   assign w_idle     = !enable || (act_q == '0);
   assign w_boundary = (cnt_q == (act_q - WIDTH'(1)));

   always_comb begin
      cnt_d   = cnt_q;
      act_d   = act_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      out_d   = out_q;
      tick_d  = 1'b0;
      w_apply = 1'b0;

      if (w_idle) begin
         cnt_d   = '0;
         out_d   = 1'b0;
         w_apply = pend_q;
      end else if (w_boundary) begin
         cnt_d   = '0;
         out_d   = ~out_q;
         tick_d  = ~out_q;
         w_apply = pend_q;
      end else begin
         cnt_d   = cnt_q + WIDTH'(1);
      end

      // Apply uses the shadow as registered, so a load in the same cycle
      // is kept for the following boundary.
      if (w_apply) begin
         act_d  = shd_q;
         pend_d = 1'b0;
      end

      if (load) begin
         shd_d  = divisor;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         act_q  <= WIDTH'(RESET_DIV);
         shd_q  <= WIDTH'(RESET_DIV);
         pend_q <= 1'b0;
         out_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         out_q  <= out_d;
         tick_q <= tick_d;
      end
   end

   assign outclk  = out_q;
   assign tick    = tick_q;
   assign pending = pend_q;

endmodule
`default_nettype wire

// File: rtl/clk_divider_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_divider_multi
// Description : CHANNELS independent clock dividers with runtime-programmable,
//               double-buffered divisors.
//               - clock in : system clock (rising edge)
//               - reset in : asynchronous, active-low
//               - bus       : clk_divider_multi_if.slave
//                             (enable, divisor, load in;
//                              outclk, tick, pending out)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_divider_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned CHANNELS  = DEF_CHANNELS,
   parameter int unsigned RESET_DIV = DEF_RESET_DIV
) (
   input  wire logic           clock,
   input  wire logic           reset,
   clk_divider_multi_if.slave  bus
);

   logic [CHANNELS-1:0] w_outclk;
   logic [CHANNELS-1:0] w_tick;
   logic [CHANNELS-1:0] w_pending;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      localparam int unsigned OFS = chan_offset(k, WIDTH);

      clk_div_channel #(
         .WIDTH     (WIDTH),
         .RESET_DIV (RESET_DIV)
      ) u_chan (
         .clock   (clock),
         .reset   (reset),
         .enable  (bus.enable[k]),
         .divisor (bus.divisor[OFS +: WIDTH]),
         .load    (bus.load[k]),
         .outclk  (w_outclk[k]),
         .tick    (w_tick[k]),
         .pending (w_pending[k])
      );
   end

   assign bus.outclk  = w_outclk;
   assign bus.tick    = w_tick;
   assign bus.pending = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_divider_multi
// Description : Directed self-checking bench for clk_divider_multi
//               (4 channels x 32 bits, RESET_DIV = 2). Inputs change and
//               outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_divider_multi;

   localparam int W = 32;
   localparam int N = 4;

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   clk_divider_multi_if #(.WIDTH(W), .CHANNELS(N)) bus ();

   clk_divider_multi #(
      .WIDTH     (W),
      .CHANNELS  (N),
      .RESET_DIV (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   // Reset pulse; returns at the falling edge right after release, so the
   // next rising edge is edge 1.
   task automatic apply_reset();
      @(negedge clock);
      reset       = 1'b0;
      bus.enable  = '1;
      bus.load    = '0;
      bus.divisor = '0;
      @(negedge clock);
      reset       = 1'b1;
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      bus.enable  = '1;
      bus.load    = '0;
      bus.divisor = '0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (bus.outclk !== 4'h0) $display("FAIL reset_outclk: got %h want 0", bus.outclk);
      else n_pass++;
      n_checks++;
      if (bus.tick !== 4'h0) $display("FAIL reset_tick: got %h want 0", bus.tick);
      else n_pass++;
      n_checks++;
      if (bus.pending !== 4'h0) $display("FAIL reset_pending: got %h want 0", bus.pending);
      else n_pass++;
      reset = 1'b1;
   endtask

   // RESET_DIV=2: rise after edges 2,6; fall after 4,8; tick at rise.
   task automatic test_default_period();
      int exp_o[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
      int exp_t[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
      apply_reset();
      for (int e = 1; e <= 8; e++) begin
         @(negedge clock);
         n_checks++;
         if (bus.outclk !== (exp_o[e-1] != 0 ? 4'hF : 4'h0))
            $display("FAIL default_outclk e%0d: got %h want %h", e, bus.outclk,
                     (exp_o[e-1] != 0 ? 4'hF : 4'h0));
         else n_pass++;
         n_checks++;
         if (bus.tick !== (exp_t[e-1] != 0 ? 4'hF : 4'h0))
            $display("FAIL default_tick e%0d: got %h want %h", e, bus.tick,
                     (exp_t[e-1] != 0 ? 4'hF : 4'h0));
         else n_pass++;
         n_checks++;
         if (bus.pending !== 4'h0) $display("FAIL default_pending e%0d: got %h want 0", e, bus.pending);
         else n_pass++;
      end
   endtask

   // Ch0 load D=1 at cnt=1: captured on edge 2, applied on edge 4 (fall).
   task automatic test_ch0_reload();
      int exp_o[5] = '{1, 0, 1, 0, 1};
      int exp_t[5] = '{0, 0, 1, 0, 1};
      int exp_p[5] = '{1, 0, 0, 0, 0};
      apply_reset();
      @(negedge clock);                    // after e1
      bus.divisor[0 +: W] = 32'd1;
      bus.load            = 4'b0001;
      @(negedge clock);                    // after e2
      n_checks++;
      if (bus.pending[0] !== 1'b1) $display("FAIL ch0_pending_e2: got %b want 1", bus.pending[0]);
      else n_pass++;
      n_checks++;
      if (bus.tick[0] !== 1'b1) $display("FAIL ch0_tick_e2: got %b want 1", bus.tick[0]);
      else n_pass++;
      bus.load = 4'b0000;
      for (int e = 3; e <= 7; e++) begin
         @(negedge clock);
         n_checks++;
         if (bus.outclk[0] !== exp_o[e-3][0])
            $display("FAIL ch0_outclk e%0d: got %b want %0d", e, bus.outclk[0], exp_o[e-3]);
         else n_pass++;
         n_checks++;
         if (bus.tick[0] !== exp_t[e-3][0])
            $display("FAIL ch0_tick e%0d: got %b want %0d", e, bus.tick[0], exp_t[e-3]);
         else n_pass++;
         n_checks++;
         if (bus.pending[0] !== exp_p[e-3][0])
            $display("FAIL ch0_pending e%0d: got %b want %0d", e, bus.pending[0], exp_p[e-3]);
         else n_pass++;
         if (e == 6) begin
            n_checks++;
            if (bus.outclk[1] !== 1'b1) $display("FAIL ch1_indep e6: got %b want 1", bus.outclk[1]);
            else n_pass++;
         end
      end
   endtask

   // Ch1 load 5 then 3 before the boundary; 3 applied on edge 4, period 6.
   task automatic test_ch1_latest_wins();
      int exp_o[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
      apply_reset();
      @(negedge clock);                    // after e1
      bus.divisor[W +: W] = 32'd5;
      bus.load            = 4'b0010;
      @(negedge clock);                    // after e2
      bus.divisor[W +: W] = 32'd3;
      @(negedge clock);                    // after e3
      n_checks++;
      if (bus.pending[1] !== 1'b1) $display("FAIL ch1_pending_e3: got %b want 1", bus.pending[1]);
      else n_pass++;
      bus.load = 4'b0000;
      for (int e = 4; e <= 13; e++) begin
         @(negedge clock);
         n_checks++;
         if (bus.outclk[1] !== exp_o[e-4][0])
            $display("FAIL ch1_outclk e%0d: got %b want %0d", e, bus.outclk[1], exp_o[e-4]);
         else n_pass++;
         n_checks++;
         if (bus.tick[1] !== ((e == 7) || (e == 13)))
            $display("FAIL ch1_tick e%0d: got %b want %0d", e, bus.tick[1], ((e == 7) || (e == 13)));
         else n_pass++;
         n_checks++;
         if (bus.pending[1] !== 1'b0) $display("FAIL ch1_pending e%0d: got %b want 0", e, bus.pending[1]);
         else n_pass++;
      end
   endtask

   // Ch2 load 0 -> idle after edge 4; load 4 at edge 7, applied edge 8,
   // first rise edge 12.
   task automatic test_ch2_idle();
      apply_reset();
      @(negedge clock);                    // after e1
      bus.divisor[2*W +: W] = 32'd0;
      bus.load              = 4'b0100;
      @(negedge clock);                    // after e2
      bus.load = 4'b0000;
      repeat (2) @(negedge clock);         // after e4
      n_checks++;
      if (bus.pending[2] !== 1'b0) $display("FAIL ch2_pending_e4: got %b want 0", bus.pending[2]);
      else n_pass++;
      for (int e = 4; e <= 6; e++) begin
         if (e > 4) @(negedge clock);
         n_checks++;
         if ({bus.outclk[2], bus.tick[2]} !== 2'b00)
            $display("FAIL ch2_idle e%0d: got %b%b want 00", e, bus.outclk[2], bus.tick[2]);
         else n_pass++;
      end
      bus.divisor[2*W +: W] = 32'd4;
      bus.load              = 4'b0100;
      @(negedge clock);                    // after e7
      n_checks++;
      if (bus.pending[2] !== 1'b1) $display("FAIL ch2_pending_e7: got %b want 1", bus.pending[2]);
      else n_pass++;
      bus.load = 4'b0000;
      @(negedge clock);                    // after e8
      n_checks++;
      if (bus.pending[2] !== 1'b0) $display("FAIL ch2_pending_e8: got %b want 0", bus.pending[2]);
      else n_pass++;
      for (int e = 9; e <= 12; e++) begin
         @(negedge clock);
         n_checks++;
         if (bus.outclk[2] !== (e == 12))
            $display("FAIL ch2_outclk e%0d: got %b want %0d", e, bus.outclk[2], (e == 12));
         else n_pass++;
         n_checks++;
         if (bus.tick[2] !== (e == 12))
            $display("FAIL ch2_tick e%0d: got %b want %0d", e, bus.tick[2], (e == 12));
         else n_pass++;
      end
   endtask

   // Ch3 disabled in its high phase with 7 pending; re-enabled before
   // edge 5 -> rise at edge 11, fall 18, rise 25.
   task automatic test_ch3_disable();
      logic exp_o;
      apply_reset();
      @(negedge clock);                    // after e1
      bus.divisor[3*W +: W] = 32'd7;
      bus.load              = 4'b1000;
      @(negedge clock);                    // after e2
      n_checks++;
      if ({bus.outclk[3], bus.pending[3]} !== 2'b11)
         $display("FAIL ch3_pre_disable: got %b%b want 11", bus.outclk[3], bus.pending[3]);
      else n_pass++;
      bus.load   = 4'b0000;
      bus.enable = 4'b0111;
      @(negedge clock);                    // after e3
      n_checks++;
      if ({bus.outclk[3], bus.tick[3], bus.pending[3]} !== 3'b000)
         $display("FAIL ch3_disabled_e3: got %b%b%b want 000", bus.outclk[3], bus.tick[3], bus.pending[3]);
      else n_pass++;
      @(negedge clock);                    // after e4
      bus.enable = 4'b1111;
      for (int e = 5; e <= 25; e++) begin
         @(negedge clock);
         exp_o = ((e >= 11) && (e <= 17)) || (e == 25);
         n_checks++;
         if (bus.outclk[3] !== exp_o)
            $display("FAIL ch3_outclk e%0d: got %b want %b", e, bus.outclk[3], exp_o);
         else n_pass++;
         if ((e == 11) || (e == 12) || (e == 25)) begin
            n_checks++;
            if (bus.tick[3] !== (e != 12))
               $display("FAIL ch3_tick e%0d: got %b want %0d", e, bus.tick[3], (e != 12));
            else n_pass++;
         end
      end
   endtask

   // All channels switched to D=3 (applied edge 4, rise edge 7), then an
   // asynchronous reset restores D=2.
   task automatic test_async_reset();
      apply_reset();
      @(negedge clock);                    // after e1
      for (int k = 0; k < N; k++) bus.divisor[k*W +: W] = 32'd3;
      bus.load = 4'hF;
      @(negedge clock);                    // after e2
      bus.load = 4'h0;
      repeat (5) @(negedge clock);         // after e7
      n_checks++;
      if ({bus.outclk, bus.tick} !== 8'hFF)
         $display("FAIL arst_pre e7: got %h want ff", {bus.outclk, bus.tick});
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.outclk, bus.tick, bus.pending} !== 12'h000)
         $display("FAIL arst_immediate: got %h want 000", {bus.outclk, bus.tick, bus.pending});
      else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);                    // after r1
      n_checks++;
      if (bus.outclk !== 4'h0) $display("FAIL arst_r1: got %h want 0", bus.outclk);
      else n_pass++;
      @(negedge clock);                    // after r2
      n_checks++;
      if ({bus.outclk, bus.tick} !== 8'hFF)
         $display("FAIL arst_r2: got %h want ff", {bus.outclk, bus.tick});
      else n_pass++;
      @(negedge clock);                    // after r3
      n_checks++;
      if ({bus.outclk, bus.tick} !== 8'hF0)
         $display("FAIL arst_r3: got %h want f0", {bus.outclk, bus.tick});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_default_period();
      test_ch0_reload();
      test_ch1_latest_wins();
      test_ch2_idle();
      test_ch3_disable();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
